// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - opcodes, instruction classes and pipeline-register types for mips_pipe_cpu
// Optional feature macro: MIPS_MUL_EN (MUL decodes as an R-type ALU op only when defined)
package mips_cpu_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // Opcode 111110 is unassigned, so it decodes as a NOP.
    localparam logic [31:0] NOP_INSTR = 32'hF800_0000;

    typedef enum logic [2:0] {
        RR_ALU,
        RM_ALU,
        LOAD,
        STORE,
        BRANCH,
        HALT,
        NOP
    } instr_class_t;

`ifdef MIPS_MUL_EN
    localparam instr_class_t MUL_CLASS = RR_ALU;
`else
    localparam instr_class_t MUL_CLASS = NOP;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] npc;
    } if_id_t;

    typedef struct packed {
        logic         valid;
        instr_class_t cls;
        logic [5:0]   op;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   dst;
        logic         we;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  imm;
        logic [31:0]  npc;
    } id_ex_t;

    typedef struct packed {
        logic         valid;
        instr_class_t cls;
        logic [31:0]  alu;
        logic [31:0]  b;
        logic [4:0]   dst;
        logic         we;
    } ex_mem_t;

    typedef struct packed {
        logic         valid;
        instr_class_t cls;
        logic [31:0]  result;
        logic [4:0]   dst;
        logic         we;
    } mem_wb_t;

    localparam if_id_t IF_ID_NOP = '{valid: 1'b0, instr: NOP_INSTR, npc: 32'd0};
    localparam id_ex_t ID_EX_NOP = '{valid: 1'b0, cls: NOP, op: NOP_INSTR[31:26], rs: 5'd0,
                                     rt: 5'd0, dst: 5'd0, we: 1'b0, a: 32'd0, b: 32'd0,
                                     imm: 32'd0, npc: 32'd0};
    localparam ex_mem_t EX_MEM_NOP = '{valid: 1'b0, cls: NOP, alu: 32'd0, b: 32'd0,
                                       dst: 5'd0, we: 1'b0};
    localparam mem_wb_t MEM_WB_NOP = '{valid: 1'b0, cls: NOP, result: 32'd0, dst: 5'd0,
                                       we: 1'b0};

    function automatic instr_class_t decode_class(input logic [5:0] op);
        instr_class_t c;
        c = NOP;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: c = RR_ALU;
            OP_MUL:                                c = MUL_CLASS;
            OP_ADDI, OP_SUBI, OP_SLTI:             c = RM_ALU;
            OP_LW:                                 c = LOAD;
            OP_SW:                                 c = STORE;
            OP_BNEQZ, OP_BEQZ:                     c = BRANCH;
            OP_HLT:                                c = HALT;
            default:                               c = NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 register file, 2 read / 1 write ports, R0 hardwired to zero
// Ports: clk_i; we_i/waddr_i/wdata_i write port; ra_addr_i/ra_data_o and rb_addr_i/rb_data_o
//        combinational read ports. A write in the same cycle is visible on the read ports.
module mips_regfile (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  ra_addr_i,
    input  logic [4:0]  rb_addr_i,
    output logic [31:0] ra_data_o,
    output logic [31:0] rb_data_o
);

    // Not reset: preloaded contents must survive a core reset.
    logic [31:0] Reg [32];

    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != 5'd0)) begin
            Reg[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        ra_data_o = Reg[ra_addr_i];
        if (we_i && (waddr_i == ra_addr_i)) ra_data_o = wdata_i;
        if (ra_addr_i == 5'd0)              ra_data_o = 32'd0;

        rb_data_o = Reg[rb_addr_i];
        if (we_i && (waddr_i == rb_addr_i)) rb_data_o = wdata_i;
        if (rb_addr_i == 5'd0)              rb_data_o = 32'd0;
    end

endmodule

// File: rtl/mips_pipe_cpu.sv
// rtl/mips_pipe_cpu.sv - 5-stage in-order MIPS-subset core with unified word memory
// Ports: clk (rising edge), rst (async active-high), halted (HLT has retired; core frozen).
// Optional feature macro: MIPS_MUL_EN enables the single-cycle MUL in EX.
module mips_pipe_cpu
    import mips_cpu_pkg::*;
#(
    parameter int MEM_DEPTH = 1024
) (
    input  logic clk,
    input  logic rst,
    output logic halted
);

    localparam int AW = $clog2(MEM_DEPTH);

    // Not reset: preloaded program/data must survive a core reset.
    logic [31:0]   Mem [MEM_DEPTH];
    logic [AW-1:0] PC;
    logic          HALTED;
    logic          TAKEN_BRANCH;

    logic [AW-1:0] pc_d;
    logic [AW-1:0] pc_plus1;
    logic          fetch_stop_q, fetch_stop_d;
    logic          halted_d;

    if_id_t  if_id_q,  if_id_d;
    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic [31:0]  rf_a, rf_b;
    logic         rf_we;
    logic [5:0]   id_op;
    instr_class_t id_cls;
    logic         id_hlt;

    logic [31:0] fwd_a, fwd_b, opb, alu;
    logic [31:0] br_target;
    logic        br_taken;
    logic [31:0] mem_rdata;
    logic        store_en;

    assign halted = HALTED;

    // ---------------- WB / register file ----------------
    assign rf_we = mem_wb_q.valid && mem_wb_q.we && !HALTED;

    mips_regfile u_rf (
        .clk_i     (clk),
        .we_i      (rf_we),
        .waddr_i   (mem_wb_q.dst),
        .wdata_i   (mem_wb_q.result),
        .ra_addr_i (if_id_q.instr[25:21]),
        .rb_addr_i (if_id_q.instr[20:16]),
        .ra_data_o (rf_a),
        .rb_data_o (rf_b)
    );

    // ---------------- ID ----------------
    always_comb begin
        id_op  = if_id_q.instr[31:26];
        id_cls = decode_class(id_op);
        id_hlt = if_id_q.valid && (id_cls == HALT);

        id_ex_d       = ID_EX_NOP;
        id_ex_d.valid = if_id_q.valid;
        id_ex_d.cls   = id_cls;
        id_ex_d.op    = id_op;
        id_ex_d.rs    = if_id_q.instr[25:21];
        id_ex_d.rt    = if_id_q.instr[20:16];
        id_ex_d.dst   = (id_cls == RR_ALU) ? if_id_q.instr[15:11] : if_id_q.instr[20:16];
        id_ex_d.we    = (id_cls == RR_ALU) || (id_cls == RM_ALU) || (id_cls == LOAD);
        id_ex_d.a     = rf_a;
        id_ex_d.b     = rf_b;
        id_ex_d.imm   = {{16{if_id_q.instr[15]}}, if_id_q.instr[15:0]};
        id_ex_d.npc   = if_id_q.npc;

        // A taken branch in EX kills the instruction currently in ID.
        if (br_taken) id_ex_d = ID_EX_NOP;
    end

    // ---------------- EX ----------------
    always_comb begin
        // The younger EX/MEM result wins over MEM/WB; R0 is never forwarded.
        fwd_a = id_ex_q.a;
        if (ex_mem_q.valid && ex_mem_q.we && (ex_mem_q.dst != 5'd0) && (ex_mem_q.dst == id_ex_q.rs))
            fwd_a = ex_mem_q.alu;
        else if (mem_wb_q.valid && mem_wb_q.we && (mem_wb_q.dst != 5'd0) && (mem_wb_q.dst == id_ex_q.rs))
            fwd_a = mem_wb_q.result;

        fwd_b = id_ex_q.b;
        if (ex_mem_q.valid && ex_mem_q.we && (ex_mem_q.dst != 5'd0) && (ex_mem_q.dst == id_ex_q.rt))
            fwd_b = ex_mem_q.alu;
        else if (mem_wb_q.valid && mem_wb_q.we && (mem_wb_q.dst != 5'd0) && (mem_wb_q.dst == id_ex_q.rt))
            fwd_b = mem_wb_q.result;

        opb = ((id_ex_q.cls == RM_ALU) || (id_ex_q.cls == LOAD) || (id_ex_q.cls == STORE))
              ? id_ex_q.imm : fwd_b;

        alu = 32'd0;
        case (id_ex_q.op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: alu = fwd_a + opb;
            OP_SUB, OP_SUBI:               alu = fwd_a - opb;
            OP_AND:                        alu = fwd_a & opb;
            OP_OR:                         alu = fwd_a | opb;
            OP_SLT, OP_SLTI:               alu = {31'd0, $signed(fwd_a) < $signed(opb)};
`ifdef MIPS_MUL_EN
            OP_MUL:                        alu = fwd_a * opb;
`endif
            default:                       alu = 32'd0;
        endcase

        br_target = id_ex_q.npc + id_ex_q.imm;
        br_taken  = id_ex_q.valid && (id_ex_q.cls == BRANCH) &&
                    ((id_ex_q.op == OP_BNEQZ) ? (fwd_a != 32'd0) : (fwd_a == 32'd0));

        ex_mem_d = '{valid: id_ex_q.valid, cls: id_ex_q.cls, alu: alu, b: fwd_b,
                     dst: id_ex_q.dst, we: id_ex_q.we};
    end

    // Target wraps modulo MEM_DEPTH, so only the low AW bits are consumed.
    logic unused_br_hi;
    assign unused_br_hi = ^br_target[31:AW];

    // ---------------- MEM ----------------
    always_comb begin
        mem_rdata = Mem[ex_mem_q.alu[AW-1:0]];
        store_en  = ex_mem_q.valid && (ex_mem_q.cls == STORE) && !HALTED;
        mem_wb_d  = '{valid: ex_mem_q.valid, cls: ex_mem_q.cls,
                      result: (ex_mem_q.cls == LOAD) ? mem_rdata : ex_mem_q.alu,
                      dst: ex_mem_q.dst, we: ex_mem_q.we};
    end

    always_ff @(posedge clk) begin
        if (store_en) begin
            Mem[ex_mem_q.alu[AW-1:0]] <= ex_mem_q.b;
        end
    end

    // ---------------- IF / next PC ----------------
    always_comb begin
        pc_plus1 = PC + AW'(1);

        // Once HLT is seen in ID (and not squashed), fetch stays off until reset.
        fetch_stop_d = fetch_stop_q || (id_hlt && !br_taken);

        if_id_d = IF_ID_NOP;
        if (!br_taken && !id_hlt && !fetch_stop_q) begin
            if_id_d = '{valid: 1'b1, instr: Mem[PC], npc: 32'(pc_plus1)};
        end

        pc_d = PC;
        if (br_taken)                        pc_d = br_target[AW-1:0];
        else if (!id_hlt && !fetch_stop_q)   pc_d = pc_plus1;

        halted_d = mem_wb_q.valid && (mem_wb_q.cls == HALT);
    end

    // ---------------- pipeline state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            fetch_stop_q <= 1'b0;
            if_id_q      <= IF_ID_NOP;
            id_ex_q      <= ID_EX_NOP;
            ex_mem_q     <= EX_MEM_NOP;
            mem_wb_q     <= MEM_WB_NOP;
        end else if (!HALTED) begin
            PC           <= pc_d;
            HALTED       <= halted_d;
            TAKEN_BRANCH <= br_taken;
            fetch_stop_q <= fetch_stop_d;
            if_id_q      <= if_id_d;
            id_ex_q      <= id_ex_d;
            ex_mem_q     <= ex_mem_d;
            mem_wb_q     <= mem_wb_d;
        end
    end

endmodule

// File: tb/tb_mips_pipe_cpu.sv
// tb/tb_mips_pipe_cpu.sv - directed scoreboard bench for mips_pipe_cpu
module tb_mips_pipe_cpu;

    localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_AND = 6'b000010;
    localparam logic [5:0] T_OR = 6'b000011, T_SLT = 6'b000100, T_MUL = 6'b000101;
    localparam logic [5:0] T_LW = 6'b001000, T_SW = 6'b001001, T_ADDI = 6'b001010;
    localparam logic [5:0] T_SUBI = 6'b001011, T_SLTI = 6'b001100;
    localparam logic [5:0] T_BNEQZ = 6'b001101, T_BEQZ = 6'b001110, T_HLT = 6'b111111;

`ifdef MIPS_MUL_EN
    localparam logic [31:0] EXP_MUL_R4 = 32'd16900;
`else
    localparam logic [31:0] EXP_MUL_R4 = 32'd7;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;

    mips_pipe_cpu dut (
        .clk    (clk),
        .rst    (rst),
        .halted (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          is_mem;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          checks = 0;
    int          errors = 0;
    int          taken_cnt = 0;

    function automatic logic [31:0] rtype(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_val(input string tag, input bit is_mem, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag    = tag;
        e.is_mem = is_mem;
        e.idx    = idx;
        e.val    = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.is_mem) obs = dut.Mem[e.idx];
            else          obs = dut.u_rf.Reg[e.idx];
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic begin_test();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) dut.u_rf.Reg[i] = 32'd0;
        prog.delete();
        sb.delete();
        taken_cnt = 0;
    endtask

    task automatic launch();
        for (int i = 0; i < prog.size(); i++) dut.Mem[i] = prog[i];
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        int k;
        k = 0;
        while (halted !== 1'b1 && k < budget) begin
            @(negedge clk);
            if (dut.TAKEN_BRANCH === 1'b1) taken_cnt++;
            k++;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    initial begin
        // ---- T1: reference program, fixed 20-cycle run ----
        begin_test();
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", 32'(dut.PC), 32'd0);
        check("rst_taken", 32'(dut.TAKEN_BRANCH), 32'd0);
        check("rst_ifid_valid", 32'(dut.if_id_q.valid), 32'd0);
        check("rst_memwb_valid", 32'(dut.mem_wb_q.valid), 32'd0);
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        expect_val("t1_r0", 0, 0, 32'd0);
        expect_val("t1_r1", 0, 1, 32'd10);
        expect_val("t1_r2", 0, 2, 32'd20);
        expect_val("t1_r3", 0, 3, 32'd25);
        expect_val("t1_r4", 0, 4, 32'd30);
        expect_val("t1_r5", 0, 5, 32'd55);
        launch();
        repeat (20) begin
            @(negedge clk);
            if (dut.TAKEN_BRANCH === 1'b1) taken_cnt++;
        end
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_taken_cnt", 32'(taken_cnt), 32'd0);
        drain();

        // ---- T2: back-to-back dependencies, R0 write discard ----
        begin_test();
        prog.push_back(itype(T_ADDI, 1, 0, 5));
        prog.push_back(rtype(T_ADD, 2, 1, 1));
        prog.push_back(rtype(T_ADD, 3, 2, 1));
        prog.push_back(itype(T_ADDI, 0, 0, 9));
        prog.push_back(rtype(T_ADD, 13, 0, 0));
        prog.push_back(itype(T_HLT, 0, 0, 0));
        expect_val("t2_r2", 0, 2, 32'd10);
        expect_val("t2_r3", 0, 3, 32'd15);
        expect_val("t2_r0", 0, 0, 32'd0);
        expect_val("t2_r13", 0, 13, 32'd0);
        launch();
        run_to_halt("t2", 100);
        drain();

        // ---- T3: loads, stores, load forwarding, MUL ----
        begin_test();
        dut.u_rf.Reg[1] = 32'd120;
        dut.u_rf.Reg[4] = 32'd7;
        prog.push_back(itype(T_LW, 2, 1, 0));
        prog.push_back(rtype(T_OR, 10, 0, 0));
        prog.push_back(rtype(T_OR, 11, 0, 0));
        prog.push_back(itype(T_ADDI, 2, 2, 45));
        prog.push_back(itype(T_SW, 2, 1, 1));
        prog.push_back(rtype(T_MUL, 4, 2, 2));
        prog.push_back(itype(T_LW, 3, 1, 0));
        prog.push_back(rtype(T_OR, 10, 0, 0));
        prog.push_back(itype(T_ADDI, 5, 3, 1));
        prog.push_back(itype(T_LW, 12, 1, 1));
        prog.push_back(itype(T_HLT, 0, 0, 0));
        expect_val("t3_mem121", 1, 121, 32'd130);
        expect_val("t3_r2", 0, 2, 32'd130);
        expect_val("t3_r4_mul", 0, 4, EXP_MUL_R4);
        expect_val("t3_r5_ldfwd", 0, 5, 32'd86);
        expect_val("t3_r12", 0, 12, 32'd130);
        launch();
        dut.Mem[120] = 32'd85;
        run_to_halt("t3", 100);
        drain();

        // ---- T4: factorial(7) by nested add loops, squashed slots ----
        begin_test();
        prog.push_back(itype(T_ADDI, 1, 0, 1));
        prog.push_back(itype(T_ADDI, 2, 0, 7));
        prog.push_back(rtype(T_ADD, 3, 0, 0));
        prog.push_back(itype(T_ADDI, 4, 2, 0));
        prog.push_back(rtype(T_ADD, 3, 3, 1));
        prog.push_back(itype(T_SUBI, 4, 4, 1));
        prog.push_back(itype(T_BNEQZ, 0, 4, -3));
        prog.push_back(itype(T_ADDI, 7, 7, 1));
        prog.push_back(rtype(T_ADD, 1, 3, 0));
        prog.push_back(itype(T_SUBI, 2, 2, 1));
        prog.push_back(itype(T_SUBI, 5, 2, 1));
        prog.push_back(itype(T_BNEQZ, 0, 5, -10));
        prog.push_back(itype(T_ADDI, 8, 8, 1));
        prog.push_back(itype(T_HLT, 0, 0, 0));
        expect_val("t4_fact", 0, 1, 32'd5040);
        expect_val("t4_slot_inner", 0, 7, 32'd6);
        expect_val("t4_slot_outer", 0, 8, 32'd1);
        launch();
        run_to_halt("t4", 2000);
        check("t4_taken_cnt", 32'(taken_cnt), 32'd26);
        drain();

        // ---- T5: SUB/AND/SLT/SLTI, BEQZ taken, BNEQZ not taken ----
        begin_test();
        prog.push_back(itype(T_ADDI, 1, 0, -5));
        prog.push_back(itype(T_ADDI, 2, 0, 3));
        prog.push_back(rtype(T_SUB, 3, 1, 2));
        prog.push_back(rtype(T_AND, 4, 1, 2));
        prog.push_back(rtype(T_SLT, 5, 1, 2));
        prog.push_back(itype(T_SLTI, 6, 2, -1));
        prog.push_back(itype(T_BEQZ, 0, 6, 2));
        prog.push_back(itype(T_ADDI, 8, 0, 1));
        prog.push_back(itype(T_ADDI, 8, 0, 2));
        prog.push_back(itype(T_BNEQZ, 0, 6, 5));
        prog.push_back(itype(T_ADDI, 10, 0, 4));
        prog.push_back(itype(T_HLT, 0, 0, 0));
        expect_val("t5_sub", 0, 3, 32'hFFFF_FFF8);
        expect_val("t5_and", 0, 4, 32'd3);
        expect_val("t5_slt", 0, 5, 32'd1);
        expect_val("t5_slti", 0, 6, 32'd0);
        expect_val("t5_squash", 0, 8, 32'd0);
        expect_val("t5_fallthru", 0, 10, 32'd4);
        launch();
        run_to_halt("t5", 100);
        check("t5_taken_cnt", 32'(taken_cnt), 32'd1);
        drain();

        // ---- T6: HLT freeze, reset after halt keeps Reg ----
        begin_test();
        prog.push_back(itype(T_ADDI, 9, 0, 3));
        prog.push_back(itype(T_HLT, 0, 0, 0));
        prog.push_back(itype(T_ADDI, 6, 0, 99));
        prog.push_back(itype(T_ADDI, 6, 0, 98));
        launch();
        run_to_halt("t6", 100);
        repeat (10) @(negedge clk);
        check("t6_r6_frozen", dut.u_rf.Reg[6], 32'd0);
        check("t6_r9", dut.u_rf.Reg[9], 32'd3);
        dut.u_rf.Reg[20] = 32'h1234_5678;
        rst = 1'b1;
        #1;
        check("t6_rst_halted", 32'(halted), 32'd0);
        check("t6_rst_pc", 32'(dut.PC), 32'd0);
        check("t6_rst_r9_kept", dut.u_rf.Reg[9], 32'd3);
        check("t6_rst_r20_kept", dut.u_rf.Reg[20], 32'h1234_5678);
        @(negedge clk);
        rst = 1'b0;
        expect_val("t6_rerun_r6", 0, 6, 32'd0);
        expect_val("t6_rerun_r9", 0, 9, 32'd3);
        expect_val("t6_rerun_r20", 0, 20, 32'h1234_5678);
        run_to_halt("t6_rerun", 100);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_pipe_cpu.md
Name: mips_pipe_cpu

Overview:
- 5-stage in-order pipelined 32-bit MIPS-subset CPU: IF, ID, EX, MEM, WB.
- Contains a unified word-addressed instruction/data memory and a 32x32 register file.
- Standalone top-level core. Benches preload program, data and registers through the hierarchical names Mem, Reg, PC, HALTED and TAKEN_BRANCH, then check the register file.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit memory words; address is the low clog2(MEM_DEPTH) bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- halted  output  1  mirrors HALTED.

Behaviour:
- Instruction format:
  - opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0], sign-extended to 32 bits.
  - R-type writes rd; I-type writes rt.
- Opcodes:
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100 (signed; result 1/0), MUL 000101 (low 32 bits).
  - LW 001000: rt = Mem[rs+imm].
  - SW 001001: Mem[rs+imm] = rt.
  - ADDI 001010, SUBI 001011, SLTI 001100.
  - BNEQZ 001101, BEQZ 001110: test rs against zero.
  - HLT 111111.
  - Any other opcode executes as a NOP.
- PC is a word index; sequential next PC = PC+1. Branch target = (branch PC + 1) + imm, wrapping modulo MEM_DEPTH.
- Register file:
  - R0 reads 0 always; writes to R0 are discarded.
  - WB write is visible to an ID read in the same cycle (write-through).
- Forwarding into EX operands:
  - EX/MEM ALU result has priority over the MEM/WB result.
  - The MEM/WB path forwards the load data for LW.
  - Consequence: dependent ALU instructions need no spacing.
  - Load-use distance 1 is unsupported; the EX operand is undefined. No interlock; software spacing of 2 is required.
- Branches:
  - Resolved in EX. When taken: TAKEN_BRANCH pulses 1 for one cycle, PC loads the target, and the two younger instructions in IF/ID and ID/EX are squashed to NOPs (no register or memory writes).
  - Not taken: no penalty.
- HLT:
  - When HLT is decoded in ID, IF stops fetching and inserts NOPs.
  - Older instructions complete.
  - When HLT reaches WB, HALTED=1 and the pipeline freezes permanently until reset. No further writes to Reg or Mem.
- Reset (async, rst=1):
  - PC=0, HALTED=0, TAKEN_BRANCH=0.
  - All pipeline registers hold NOP (valid=0), halted=0.
  - Reg and Mem are NOT cleared, so preloaded contents survive reset.
  - Reset mid-execution discards in-flight instructions; fetch restarts at 0 on the first edge after deassertion.
- Latency:
  - An instruction fetched in cycle n writes back at the end of cycle n+4.
  - Throughput is one instruction per cycle.
- Arithmetic: 32-bit two's complement, overflow ignored. Memory address uses low bits only (wrap).

Optional Feature:
- MIPS_MUL_EN defined: MUL opcode supported (rd = low 32 bits of rs*rt, single-cycle in EX).
- MIPS_MUL_EN undefined: no multiplier is synthesized and MUL executes as a NOP (rd unchanged).

Decomposition:
- Package mips_cpu_pkg holds:
  - opcode localparams;
  - instruction-class enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP);
  - the pipeline-register struct typedefs (IF/ID, ID/EX, EX/MEM, MEM/WB, each with a valid bit);
  - the NOP encoding.
- One sub-module, mips_regfile: 32x32 array named Reg, 2 read ports, 1 write port, R0 hardwired zero, write-through.

Test Plan:
- Reg cleared, Mem[0..8] = 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000. Run 20 cycles -> R0=0, R1=10, R2=20, R3=25, R4=30, R5=55, halted=1.
- Back-to-back dependency: ADDI R1,R0,5; ADD R2,R1,R1; ADD R3,R2,R1; HLT -> R2=10, R3=15.
- Memory:
  - Mem[120]=85; LW R2,0(R1) with R1=120; two dummy ORs; ADDI R2,R2,45; SW R2,1(R1); HLT -> Mem[121]=130.
  - Same program with MIPS_MUL_EN defined and MUL R4,R2,R2 -> R4=16900.
- Branch loop: factorial of 7 using BNEQZ with squashed delay slots -> result 5040; instruction after a taken branch must not write.
- HLT freeze:
  - Instructions after HLT in Mem (ADDI R6,R0,99) leave R6=0.
  - Pulsing rst after halt with Reg preloaded -> HALTED=0, PC restarts at 0, Reg contents retained.
